// File: rtl/sprite_draw_ctrl.sv
// Frame-buffer draw controller for one horizontally moving sprite: paints the background,
// then loops draw / wait / erase / move on move requests, with edge clamping and a one-deep request buffer.
module sprite_draw_ctrl #(
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120,
   parameter int SPR_W    = 16,
   parameter int SPR_H    = 16,
   parameter int SPR_Y    = 96,
   parameter int START_X  = 0,
   parameter int STEP     = 4,
   parameter int XW       = 8,
   parameter int YW       = 7
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          move_req,
   input  logic          dir,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic          plot,
   output logic [1:0]    src_sel,
   output logic [XW-1:0] spr_x,
   output logic          busy,
   output logic          blocked
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRAW_BG,
      S_DRAW_SPR,
      S_WAIT,
      S_ERASE,
      S_MOVE
   } state_t;

   localparam logic [XW-1:0] BG_LAST_X  = XW'(SCREEN_W - 1);
   localparam logic [YW-1:0] BG_LAST_Y  = YW'(SCREEN_H - 1);
   localparam logic [XW-1:0] SPR_LAST_X = XW'(SPR_W - 1);
   localparam logic [YW-1:0] SPR_LAST_Y = YW'(SPR_H - 1);
   localparam logic [YW-1:0] SPR_TOP    = YW'(SPR_Y);
   localparam logic [XW-1:0] START_POS  = XW'(START_X);
   localparam logic [XW-1:0] STEP_X     = XW'(STEP);
   localparam logic [XW:0]   STEP_WIDE  = (XW+1)'(STEP);
   localparam logic [XW:0]   RIGHT_LIM  = (XW+1)'(SCREEN_W - SPR_W);

   state_t        state_q, state_d;
   logic [XW-1:0] col_q, col_d;
   logic [YW-1:0] row_q, row_d;
   logic [XW-1:0] spr_x_q, spr_x_d;
   logic          pend_q, pend_d;
   logic          pend_dir_q, pend_dir_d;
   logic          mv_dir_q, mv_dir_d;
   logic          blocked_q, blocked_d;

   logic          scan_busy;
   logic          bg_last_col, bg_done, spr_last_col, spr_done;
   logic          req_v, req_dir, legal;
   logic [XW:0]   right_sum;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         col_q      <= '0;
         row_q      <= '0;
         spr_x_q    <= START_POS;
         pend_q     <= 1'b0;
         pend_dir_q <= 1'b0;
         mv_dir_q   <= 1'b0;
         blocked_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         col_q      <= col_d;
         row_q      <= row_d;
         spr_x_q    <= spr_x_d;
         pend_q     <= pend_d;
         pend_dir_q <= pend_dir_d;
         mv_dir_q   <= mv_dir_d;
         blocked_q  <= blocked_d;
      end
   end

   assign scan_busy    = (state_q == S_DRAW_BG) || (state_q == S_DRAW_SPR) ||
                         (state_q == S_ERASE)   || (state_q == S_MOVE);
   assign bg_last_col  = (col_q == BG_LAST_X);
   assign bg_done      = bg_last_col && (row_q == BG_LAST_Y);
   assign spr_last_col = (col_q == SPR_LAST_X);
   assign spr_done     = spr_last_col && (row_q == SPR_LAST_Y);

   // A buffered request takes priority over a fresh pulse in WAIT; one bit of headroom avoids wrap.
   assign req_v     = pend_q | move_req;
   assign req_dir   = pend_q ? pend_dir_q : dir;
   assign right_sum = {1'b0, spr_x_q} + STEP_WIDE;
   assign legal     = req_dir ? ({1'b0, spr_x_q} >= STEP_WIDE) : (right_sum <= RIGHT_LIM);

   always_comb begin
      state_d    = state_q;
      col_d      = col_q;
      row_d      = row_q;
      spr_x_d    = spr_x_q;
      pend_d     = pend_q;
      pend_dir_d = pend_dir_q;
      mv_dir_d   = mv_dir_q;
      blocked_d  = 1'b0;

      if (move_req && !pend_q && (scan_busy || ((state_q == S_IDLE) && start))) begin
         pend_d     = 1'b1;
         pend_dir_d = dir;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_DRAW_BG;
               col_d   = '0;
               row_d   = '0;
            end
         end
         S_DRAW_BG: begin
            if (bg_last_col) begin
               col_d = '0;
               if (bg_done) begin
                  row_d   = '0;
                  state_d = S_DRAW_SPR;
               end else begin
                  row_d = row_q + 1'b1;
               end
            end else begin
               col_d = col_q + 1'b1;
            end
         end
         S_DRAW_SPR, S_ERASE: begin
            if (spr_last_col) begin
               col_d = '0;
               if (spr_done) begin
                  row_d   = '0;
                  state_d = (state_q == S_ERASE) ? S_MOVE : S_WAIT;
               end else begin
                  row_d = row_q + 1'b1;
               end
            end else begin
               col_d = col_q + 1'b1;
            end
         end
         S_WAIT: begin
            if (req_v) begin
               pend_d = 1'b0;
               if (legal) begin
                  state_d  = S_ERASE;
                  mv_dir_d = req_dir;
                  col_d    = '0;
                  row_d    = '0;
               end else begin
                  blocked_d = 1'b1;
               end
            end
         end
         S_MOVE: begin
            spr_x_d = mv_dir_q ? (spr_x_q - STEP_X) : (spr_x_q + STEP_X);
            state_d = S_DRAW_SPR;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      x       = '0;
      y       = '0;
      plot    = 1'b0;
      src_sel = 2'b00;
      busy    = 1'b0;
      case (state_q)
         S_DRAW_BG: begin
            plot    = 1'b1;
            src_sel = 2'b01;
            x       = col_q;
            y       = row_q;
            busy    = 1'b1;
         end
         S_DRAW_SPR, S_ERASE: begin
            plot    = 1'b1;
            src_sel = (state_q == S_ERASE) ? 2'b11 : 2'b10;
            x       = spr_x_q + col_q;
            y       = SPR_TOP + row_q;
            busy    = 1'b1;
         end
         S_MOVE:  busy = 1'b1;
         default: busy = 1'b0;
      endcase
   end

   assign spr_x   = spr_x_q;
   assign blocked = blocked_q;

endmodule

// File: tb/tb_sprite_draw_ctrl.sv
// Bench for sprite_draw_ctrl: random move sequences checked against a position model,
// raster-order pixel expectations and an erase-versus-draw scoreboard.
module tb_sprite_draw_ctrl;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;
   localparam int SPR_W    = 16;
   localparam int SPR_H    = 16;
   localparam int SPR_Y    = 96;
   localparam int STEP     = 4;
   localparam int NSPR     = SPR_W * SPR_H;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       move_req = 1'b0;
   logic       dir = 1'b0;
   logic [7:0] x;
   logic [6:0] y;
   logic       plot;
   logic [1:0] src_sel;
   logic [7:0] spr_x;
   logic       busy;
   logic       blocked;

   int errors = 0;
   int checks = 0;
   int spr_x_m;
   int draw_q[$];
   int cur_q[$];

   always #5 clk = ~clk;

   sprite_draw_ctrl #(
      .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .SPR_W(SPR_W), .SPR_H(SPR_H),
      .SPR_Y(SPR_Y), .START_X(0), .STEP(STEP), .XW(8), .YW(7)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .move_req(move_req), .dir(dir),
      .x(x), .y(y), .plot(plot), .src_sel(src_sel), .spr_x(spr_x),
      .busy(busy), .blocked(blocked)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Called at the negedge showing the first pixel; leaves at the negedge after the last one.
   task automatic expect_scan(input string tag, input logic [1:0] src, input int x0, input int y0,
                              input int w, input int n, input int req_a, input int req_b);
      int bad;
      int oob;
      bad = 0;
      oob = 0;
      cur_q.delete();
      for (int i = 0; i < n; i++) begin
         if (plot !== 1'b1 || busy !== 1'b1 || src_sel !== src ||
             x !== 8'(x0 + i % w) || y !== 7'(y0 + i / w)) bad++;
         if (int'(x) >= SCREEN_W || int'(y) >= SCREEN_H) oob++;
         cur_q.push_back(int'(x) * 256 + int'(y));
         move_req = (i == req_a) || (i == req_b);
         dir      = 1'b0;
         @(negedge clk);
      end
      move_req = 1'b0;
      chk({tag, " bad_pixels"}, bad, 0);
      chk({tag, " out_of_bounds"}, oob, 0);
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, " outputs"}, {x, y, plot, src_sel, busy, blocked}, 0);
      chk({tag, " spr_x"}, spr_x, 0);
   endtask

   // Entered at the negedge showing the first erase pixel of an accepted move.
   task automatic move_body(input bit d);
      int diff;
      expect_scan("erase", 2'b11, spr_x_m, SPR_Y, SPR_W, NSPR, -1, -1);
      diff = 0;
      foreach (cur_q[i]) if (i >= draw_q.size() || cur_q[i] != draw_q[i]) diff++;
      chk("erase_set_size", cur_q.size(), draw_q.size());
      chk("erase_set_matches_draw", diff, 0);
      chk("move_cycle", {busy, plot, src_sel}, 4'b1000);
      @(negedge clk);
      spr_x_m = d ? spr_x_m - STEP : spr_x_m + STEP;
      chk("spr_x_after_move", spr_x, spr_x_m);
      expect_scan("draw", 2'b10, spr_x_m, SPR_Y, SPR_W, NSPR, -1, -1);
      draw_q = cur_q;
      chk("wait_after_draw", {busy, plot}, 0);
   endtask

   task automatic do_move(input bit d);
      bit legal;
      legal    = d ? (spr_x_m >= STEP) : (spr_x_m + STEP <= SCREEN_W - SPR_W);
      move_req = 1'b1;
      dir      = d;
      @(negedge clk);
      move_req = 1'b0;
      dir      = 1'b0;
      if (legal) begin
         move_body(d);
      end else begin
         chk("blocked_pulse", {blocked, plot, busy}, 3'b100);
         chk("blocked_spr_x", spr_x, spr_x_m);
         @(negedge clk);
         chk("blocked_one_cycle", {blocked, busy, plot}, 0);
      end
   endtask

   initial begin
      int act;
      bit d;
      spr_x_m = 0;
      reset   = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_state("reset");
      reset = 1'b1;
      @(negedge clk);
      chk("idle_quiet", {busy, plot}, 0);

      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      expect_scan("bg", 2'b01, 0, 0, SCREEN_W, SCREEN_W * SCREEN_H, -1, -1);
      chk("bg_last_xy", cur_q[cur_q.size() - 1], 159 * 256 + 119);
      expect_scan("spr_init", 2'b10, 0, SPR_Y, SPR_W, NSPR, -1, -1);
      draw_q = cur_q;
      chk("wait_after_init", {busy, plot}, 0);

      do_move(1'b1);
      do_move(1'b0);
      chk("first_move_x", spr_x, 4);
      while (spr_x_m < SCREEN_W - SPR_W) do_move(1'b0);
      chk("at_right_edge", spr_x, 144);
      do_move(1'b0);
      for (int k = 0; k < 10; k++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         do_move(1'($urandom_range(0, 1)));
      end

      d        = (spr_x_m >= STEP);
      move_req = 1'b1;
      dir      = d;
      @(negedge clk);
      move_req = 1'b0;
      dir      = 1'b0;
      expect_scan("erase_part", 2'b11, spr_x_m, SPR_Y, SPR_W, 100, -1, -1);
      reset = 1'b0;
      @(negedge clk);
      check_reset_state("mid_erase_reset");
      @(negedge clk);
      reset   = 1'b1;
      spr_x_m = 0;
      @(negedge clk);

      move_req = 1'b1;
      dir      = 1'b1;
      @(negedge clk);
      move_req = 1'b0;
      dir      = 1'b0;
      chk("idle_req_ignored", {busy, plot, blocked}, 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      expect_scan("bg2", 2'b01, 0, 0, SCREEN_W, SCREEN_W * SCREEN_H, 50, 3000);
      chk("redraw_origin", cur_q[0], 0);
      expect_scan("spr2", 2'b10, 0, SPR_Y, SPR_W, NSPR, -1, -1);
      draw_q = cur_q;
      chk("wait_before_pending", {busy, blocked}, 0);
      @(negedge clk);
      move_body(1'b0);
      chk("pending_move_x", spr_x, 4);
      act = 0;
      repeat (20) begin
         @(negedge clk);
         if (busy !== 1'b0 || plot !== 1'b0 || blocked !== 1'b0) act++;
      end
      chk("second_req_dropped", act, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
